// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, one parity bit, one or more stop bits.
// The line is sampled once at mid-bit; each byte is delivered with a one-cycle strobe and error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 3,
    parameter bit PARITY       = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    // The counter expires on its zero count, so the load values are one less than the spacing wanted.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       sync_reg;
    logic             rx_s;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             par_bit_reg;
    logic [7:0]       data_rx_reg;
    logic             rx_valid_reg;
    logic             parity_err_reg;
    logic             frame_err_reg;
    logic             tick;

    // Two-flop synchronizer; it resets to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];
    assign tick = (cnt_reg == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (tick) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (tick && (bit_cnt_reg == 3'd7)) state_next = PAR;
            end
            PAR: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                // A low stop bit parks in WAIT_HIGH so a held break yields a single error frame.
                if (tick) state_next = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy = 1'b0;
        case (state_reg)
            START, DATA, PAR, STOP: rx_busy = 1'b1;
            default:                rx_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg        <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            par_bit_reg    <= 1'b0;
            data_rx_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= HALF_LOAD;
                end
                START: begin
                    if (tick) begin
                        cnt_reg     <= BIT_LOAD;
                        bit_cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_reg     <= BIT_LOAD;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                PAR: begin
                    if (tick) begin
                        cnt_reg     <= BIT_LOAD;
                        par_bit_reg <= rx_s;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                STOP: begin
                    if (tick) begin
                        data_rx_reg    <= shift_reg;
                        parity_err_reg <= ((^shift_reg) ^ PARITY) != par_bit_reg;
                        frame_err_reg  <= ~rx_s;
                        rx_valid_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_rx    = data_rx_reg;
    assign rx_valid   = rx_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a fast instance (3 clocks/bit, even parity) and a slow one (16 clocks/bit, odd parity),
// driven with directed and random frames and checked against a frame-level model of expected deliveries.
module tb_uart_rx;

    localparam int       CPB_A = 3;
    localparam int       CPB_B = 16;
    localparam bit       PAR_A = 1'b0;
    localparam bit       PAR_B = 1'b1;

    logic       clk = 1'b0;
    logic       rst_a, rst_b, rx_a, rx_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         inst;
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       busy;
    } rec_t;

    rec_t got_q[$];
    rec_t exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB_A), .PARITY(PAR_A)) dut_a (
        .clk(clk), .reset(rst_a), .rx(rx_a), .data_rx(data_a), .rx_valid(valid_a),
        .parity_err(pe_a), .frame_err(fe_a), .rx_busy(busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B), .PARITY(PAR_B)) dut_b (
        .clk(clk), .reset(rst_b), .rx(rx_b), .data_rx(data_b), .rx_valid(valid_b),
        .parity_err(pe_b), .frame_err(fe_b), .rx_busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a) got_q.push_back('{0, cyc, data_a, pe_a, fe_a, busy_a});
        if (valid_b) got_q.push_back('{1, cyc, data_b, pe_b, fe_b, busy_b});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cpb_of(input int inst);
        return (inst != 0) ? CPB_B : CPB_A;
    endfunction

    // Correct parity bit for a byte: even parity is the XOR of the data bits, odd parity its inverse.
    function automatic logic ref_parity(input int inst, input logic [7:0] d);
        logic ones_odd;
        ones_odd = ($countones(d) % 2) == 1;
        return ones_odd ^ ((inst != 0) ? PAR_B : PAR_A);
    endfunction

    task automatic set_line(input int inst, input logic v);
        if (inst != 0) rx_b = v;
        else           rx_a = v;
    endtask

    task automatic hold_bit(input int inst, input logic v);
        set_line(inst, v);
        repeat (cpb_of(inst)) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Delivery is due 2 sync cycles + half a bit + 10 bit times + 1 register cycle after the pin falls.
    task automatic send_frame(input int inst, input logic [7:0] d, input logic pbit,
                              input logic stop_ok, input int nstop);
        rec_t e;
        int   cpb;
        cpb    = cpb_of(inst);
        e.inst = inst;
        e.t    = cyc + 3 + (cpb - 1) / 2 + 10 * cpb;
        e.d    = d;
        e.pe   = (pbit != ref_parity(inst, d));
        e.fe   = !stop_ok;
        e.busy = 1'b0;
        exp_q.push_back(e);
        hold_bit(inst, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) check("busy_mid_frame", (inst != 0) ? busy_b : busy_a, 1'b1);
            hold_bit(inst, d[i]);
        end
        hold_bit(inst, pbit);
        if (stop_ok) begin
            for (int s = 0; s < nstop; s++) hold_bit(inst, 1'b1);
        end else begin
            hold_bit(inst, 1'b0);
        end
    endtask

    task automatic drain();
        rec_t g, e;
        check("frame_count", got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            $display("[TB] frame inst=%0d t=%0d data=%02h pe=%0b fe=%0b (model t=%0d data=%02h pe=%0b fe=%0b)",
                     g.inst, g.t, g.d, g.pe, g.fe, e.t, e.d, e.pe, e.fe);
            check("instance", g.inst, e.inst);
            check("valid_cycle", g.t, e.t);
            check("data_rx", g.d, e.d);
            check("parity_err", g.pe, e.pe);
            check("frame_err", g.fe, e.fe);
            check("busy_at_valid", g.busy, e.busy);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] bytes_b [4];
        logic [7:0] d;
        int         inst;
        logic       pbit, stop_ok;

        rst_a = 1'b0;
        rst_b = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            rx_a = ~rx_a;
            rx_b = ~rx_b;
        end
        check("reset_outputs_a", {data_a, valid_a, pe_a, fe_a, busy_a}, 12'h000);
        check("reset_outputs_b", {data_b, valid_b, pe_b, fe_b, busy_b}, 12'h000);
        @(negedge clk);
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        idle(100);
        drain();

        // Single frame with latency check, then a parity error cleared by a good frame.
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1);
        idle(12);
        drain();
        send_frame(0, 8'h01, 1'b0, 1'b1, 1);
        idle(12);
        check("parity_err_held", pe_a, 1'b1);
        send_frame(0, 8'h01, 1'b1, 1'b1, 1);
        idle(12);
        drain();

        // Bad stop bit followed by a long break: one error frame, then normal reception resumes.
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1);
        idle(50 * CPB_A);
        check("frame_err_held", fe_a, 1'b1);
        drain();
        set_line(0, 1'b1);
        idle(10);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1);
        idle(12);
        drain();

        // Back-to-back frames on the slow instance, then a short idle glitch.
        bytes_b = '{8'h00, 8'hFF, 8'h55, 8'hAA};
        for (int i = 0; i < 4; i++) send_frame(1, bytes_b[i], ref_parity(1, bytes_b[i]), 1'b1, 1);
        idle(40);
        drain();
        set_line(1, 1'b0);
        idle(5);
        set_line(1, 1'b1);
        idle(60);
        drain();

        // Reset during data bit 4 abandons the frame; the next frame is intact.
        d = 8'hC3;
        hold_bit(1, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1, d[i]);
        set_line(1, d[4]);
        idle(8);
        rst_b = 1'b0;
        rx_b  = 1'b1;
        idle(3);
        check("midframe_reset_outputs", {data_b, valid_b, pe_b, fe_b, busy_b}, 12'h000);
        rst_b = 1'b1;
        idle(40);
        send_frame(1, 8'h7E, ref_parity(1, 8'h7E), 1'b1, 1);
        idle(40);
        drain();

        // Random traffic across both instances.
        for (int k = 0; k < 24; k++) begin
            inst    = int'($urandom_range(0, 1));
            d       = 8'($urandom_range(0, 255));
            pbit    = ref_parity(inst, d) ^ ($urandom_range(0, 3) == 0);
            stop_ok = ($urandom_range(0, 5) != 0);
            send_frame(inst, d, pbit, stop_ok, int'($urandom_range(1, 2)));
            if (!stop_ok) begin
                hold_bit(inst, 1'b1);
                hold_bit(inst, 1'b1);
            end
            idle(int'($urandom_range(0, cpb_of(inst))));
        end
        idle(60);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
